// File: rtl/memory_write_control.sv
`default_nettype none
// ============================================================================
// Module   : memory_write_control
// Brief    : Streams bytes into a synchronous RAM from address 0 upward and
//            stops at full; optional read-back verify under MEMWR_VERIFY_EN.
// Revision : 1.0
// ============================================================================
module memory_write_control #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_clear,
  input  logic [DATA_W-1:0] i_data_in,
  input  logic              i_data_valid,
  output logic              o_ready,
  output logic [ADDR_W-1:0] o_addr,
  output logic [DATA_W-1:0] o_wr_data,
  output logic              o_wr_en,
  output logic              o_rd_en,
  input  logic [DATA_W-1:0] i_rd_data,
  output logic              o_full,
  output logic [ADDR_W:0]   o_count,
  output logic              o_error,
  output logic [ADDR_W-1:0] o_err_addr
);

  localparam int              c_DEPTH_I   = 1 << ADDR_W;
  localparam logic [ADDR_W:0] c_DEPTH     = (ADDR_W+1)'(c_DEPTH_I);
  localparam logic [2:0]      c_ST_ACCEPT = 3'd0;
  localparam logic [2:0]      c_ST_FULL   = 3'd4;
`ifdef MEMWR_VERIFY_EN
  localparam logic [2:0]      c_ST_WR     = 3'd1;
  localparam logic [2:0]      c_ST_RD     = 3'd2;
  localparam logic [2:0]      c_ST_CMP    = 3'd3;
`endif

  logic [2:0]        r_state;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W:0]   r_count;
  logic              r_full;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wr_data;
  logic              r_wr_en;
  logic              w_ready;
  logic              w_accept;
  logic [ADDR_W:0]   w_count_nxt;

  assign w_ready     = (r_state == c_ST_ACCEPT) && !i_reset && !i_clear;
  assign w_accept    = i_data_valid && w_ready;
  assign w_count_nxt = r_count + 1'b1;

`ifdef MEMWR_VERIFY_EN
  logic              r_rd_en;
  logic              r_error;
  logic [ADDR_W-1:0] r_err_addr;
`else
  logic              w_last;
  logic              w_unused_rd;
  assign w_last      = (w_count_nxt == c_DEPTH);
  assign w_unused_rd = ^i_rd_data;
`endif

  // Clear behaves like Reset for the datapath; only the verify error state differs.
  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      r_state   <= c_ST_ACCEPT;
      r_ptr     <= '0;
      r_count   <= '0;
      r_full    <= 1'b0;
      r_addr    <= '0;
      r_wr_data <= '0;
      r_wr_en   <= 1'b0;
`ifdef MEMWR_VERIFY_EN
      r_rd_en   <= 1'b0;
`endif
    end else begin
      r_wr_en <= 1'b0;
`ifdef MEMWR_VERIFY_EN
      r_rd_en <= 1'b0;
`endif
      case (r_state)
        c_ST_ACCEPT: begin
          if (w_accept) begin
            r_addr    <= r_ptr;
            r_wr_data <= i_data_in;
            r_wr_en   <= 1'b1;
            r_ptr     <= r_ptr + 1'b1;
            r_count   <= w_count_nxt;
`ifdef MEMWR_VERIFY_EN
            r_state   <= c_ST_WR;
`else
            if (w_last) begin
              r_state <= c_ST_FULL;
              r_full  <= 1'b1;
            end
`endif
          end
        end
`ifdef MEMWR_VERIFY_EN
        c_ST_WR: begin
          r_rd_en <= 1'b1;
          r_state <= c_ST_RD;
        end
        c_ST_RD: begin
          r_state <= c_ST_CMP;
        end
        c_ST_CMP: begin
          if (r_count == c_DEPTH) begin
            r_state <= c_ST_FULL;
            r_full  <= 1'b1;
          end else begin
            r_state <= c_ST_ACCEPT;
          end
        end
`endif
        c_ST_FULL: begin
          r_state <= c_ST_FULL;
        end
        default: begin
          r_state <= c_ST_ACCEPT;
        end
      endcase
    end
  end

`ifdef MEMWR_VERIFY_EN
  // WrData still holds the byte under test while in CMP, so it doubles as the saved copy.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_error    <= 1'b0;
      r_err_addr <= '0;
    end else if (!i_clear && (r_state == c_ST_CMP) && (i_rd_data != r_wr_data)) begin
      r_error <= 1'b1;
      if (!r_error) begin
        r_err_addr <= r_addr;
      end
    end
  end

  assign o_rd_en    = r_rd_en;
  assign o_error    = r_error;
  assign o_err_addr = r_err_addr;
`else
  assign o_rd_en    = 1'b0;
  assign o_error    = 1'b0;
  assign o_err_addr = '0;
`endif

  assign o_ready   = w_ready;
  assign o_addr    = r_addr;
  assign o_wr_data = r_wr_data;
  assign o_wr_en   = r_wr_en;
  assign o_full    = r_full;
  assign o_count   = r_count;

endmodule
`default_nettype wire
